// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable frame format (5..9 data bits, none/even/odd parity, 1/2 stop bits), fronted by a write FIFO.
// Latency: the start bit begins 1 cycle after the accept edge when idle; each bit lasts DIV = CLK_FREQ/BAUD_RATE cycles.
// Backpressure: tx_ready is low while the FIFO is full. tx_enable low holds new frames at the frame boundary and never cuts a frame.

module uart_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       core_clk,
    input  logic                       arst_n,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    output logic                       push_rdy,
    output logic                       pop_vld,
    input  logic                       pop_rdy,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_go;
    logic          pop_go;

    assign push_rdy = (count != CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign push_go  = push_vld && push_rdy;
    assign pop_go   = pop_rdy && pop_vld;
    assign pop_dat  = mem[rd_ptr];

    // Storage array has no reset; flushing only needs the pointers and the count cleared.
    always_ff @(posedge core_clk) begin
        if (push_go) mem[wr_ptr] <= push_dat;
    end

    // Pointer and occupancy tracking; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_go) wr_ptr <= wr_ptr + AW'(1);
            if (pop_go)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_go, pop_go})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_tx_cfg #(
    parameter int CLK_FREQ   = 1_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          tx_enable,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DIV   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = 4;

    // Illegal parameter combinations stop elaboration.
    if (DIV < 2) begin : g_bad_div
        $fatal(1, "uart_tx_cfg: CLK_FREQ/BAUD_RATE must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "uart_tx_cfg: FIFO_DEPTH must be a power of 2, >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $fatal(1, "uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $fatal(1, "uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $fatal(1, "uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       baud_cnt;
    logic [BIT_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shift_dat;
    logic                   par_bit;
    logic                   fifo_vld;
    logic [DATA_BITS-1:0]   fifo_dat;
    logic                   cnt_last;
    logic                   stop_last;
    logic                   start_go;

    assign cnt_last  = (baud_cnt == CNT_W'(DIV - 1));
    assign stop_last = (bit_idx == BIT_W'(STOP_BITS - 1));
    // A new frame may only start at a frame boundary: from IDLE, or on the last cycle of the final stop bit.
    assign start_go  = fifo_vld && tx_enable &&
                       ((state == IDLE) || ((state == STOP) && cnt_last && stop_last));
    assign tx_busy   = (state != IDLE) || (fifo_count != '0);

    uart_tx_fifo #(
        .W     (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (clk),
        .arst_n   (rst_n),
        .push_vld (tx_valid),
        .push_dat (tx_data),
        .push_rdy (tx_ready),
        .pop_vld  (fifo_vld),
        .pop_rdy  (start_go),
        .pop_dat  (fifo_dat),
        .count    (fifo_count)
    );

    // Frame sequencer: baud timing, bit selection and the registered serial output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_dat <= '0;
            par_bit   <= 1'b0;
            tx_serial <= 1'b1;
        end else if (start_go) begin
            state     <= START;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_dat <= fifo_dat;
            par_bit   <= (^fifo_dat) ^ (PARITY == 2);
            tx_serial <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                end
                START: begin
                    if (cnt_last) begin
                        state     <= DATA;
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        tx_serial <= shift_dat[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                state     <= PAR;
                                tx_serial <= par_bit;
                            end else begin
                                state     <= STOP;
                                tx_serial <= 1'b1;
                            end
                        end else begin
                            bit_idx   <= bit_idx + BIT_W'(1);
                            shift_dat <= shift_dat >> 1;
                            tx_serial <= shift_dat[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                PAR: begin
                    if (cnt_last) begin
                        state     <= STOP;
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        tx_serial <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_last) begin
                        baud_cnt <= '0;
                        if (stop_last) begin
                            state   <= IDLE;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                    tx_serial <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    tx_serial <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: four instances covering 8N1, 8E1, 8O1 and 5N2 frames, all at DIV=10.
// Latency: checks the start bit 1 cycle after the accept edge and every line cycle of each frame.
// Backpressure: exercises FIFO full, tx_enable hold-off, simultaneous push/pop and mid-frame reset.

module tb_uart_tx_cfg;
    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic [3:0] vld;
    logic [3:0] en;
    logic [3:0] rdy;
    logic [3:0] ser;
    logic [3:0] busy;
    logic [3:0] cnt [4];

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(8),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld[0]), .tx_ready(rdy[0]),
        .tx_enable(en[0]), .tx_serial(ser[0]), .tx_busy(busy[0]), .fifo_count(cnt[0]));

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(8),
                  .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld[1]), .tx_ready(rdy[1]),
        .tx_enable(en[1]), .tx_serial(ser[1]), .tx_busy(busy[1]), .fifo_count(cnt[1]));

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(8),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(vld[2]), .tx_ready(rdy[2]),
        .tx_enable(en[2]), .tx_serial(ser[2]), .tx_busy(busy[2]), .fifo_count(cnt[2]));

    uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(8),
                  .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_d (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[4:0]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
        .tx_enable(en[3]), .tx_serial(ser[3]), .tx_busy(busy[3]), .fifo_count(cnt[3]));

    // One frame per record: line bit k of the frame is frame[k], start bit first.
    typedef struct {
        int          dut;
        logic [7:0]  data;
        logic [11:0] frame;
        int          nbits;
    } vec_t;

    vec_t       vt [9];
    logic [7:0] sw [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected 8N1 line level for bit position j of a frame carrying w.
    function automatic logic exp_8n1(input logic [7:0] w, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return w[j-1];
        return 1'b1;
    endfunction

    // Called at the sample point of the first start-bit cycle on instance A; follows n back-to-back frames.
    task automatic check_stream(input string name, input int n);
        int errs = 0;
        for (int k = 0; k < n * 10 * DIV; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (ser[0] !== exp_8n1(sw[k / (10 * DIV)], (k % (10 * DIV)) / DIV)) errs++;
            if (busy[0] !== 1'b1) errs++;
        end
        chk({name, "_wave_errs"}, errs, 0);
        @(posedge clk);
        #1;
        chk({name, "_busy_end"}, busy[0], 1'b0);
        chk({name, "_count_end"}, cnt[0], 0);
    endtask

    initial begin
        vt[0] = '{0, 8'h55, 12'h2AA, 10};
        vt[1] = '{0, 8'h00, 12'h200, 10};
        vt[2] = '{0, 8'hFF, 12'h3FE, 10};
        vt[3] = '{1, 8'hA3, 12'h546, 11};
        vt[4] = '{1, 8'h01, 12'h602, 11};
        vt[5] = '{2, 8'hA3, 12'h746, 11};
        vt[6] = '{2, 8'h01, 12'h402, 11};
        vt[7] = '{3, 8'h1F, 12'h0FE, 8};
        vt[8] = '{3, 8'h0A, 12'h0D4, 8};

        rst_n   = 1'b0;
        tx_data = '0;
        vld     = '0;
        en      = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_serial_%0d", d), ser[d], 1'b1);
            chk($sformatf("rst_busy_%0d", d), busy[d], 1'b0);
            chk($sformatf("rst_ready_%0d", d), rdy[d], 1'b1);
            chk($sformatf("rst_count_%0d", d), cnt[d], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single-frame vectors.
        for (int i = 0; i < 9; i++) begin
            int          d;
            int          errs;
            logic [11:0] fr;
            d    = vt[i].dut;
            fr   = vt[i].frame;
            errs = 0;
            @(negedge clk);
            tx_data = vt[i].data;
            vld[d]  = 1'b1;
            @(posedge clk);
            #1;
            vld[d] = 1'b0;
            chk($sformatf("v%0d_pre_start", i), ser[d], 1'b1);
            for (int k = 0; k < vt[i].nbits * DIV; k++) begin
                @(posedge clk);
                #1;
                if (ser[d] !== fr[k / DIV]) errs++;
                if (busy[d] !== 1'b1) errs++;
            end
            chk($sformatf("v%0d_frame_errs", i), errs, 0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_busy_end", i), busy[d], 1'b0);
            chk($sformatf("v%0d_serial_idle", i), ser[d], 1'b1);
        end

        // FIFO full with tx_enable low: the ninth word is dropped.
        @(negedge clk);
        en[0] = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            tx_data = 8'(i);
            vld[0]  = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("full_count_%0d", i), cnt[0], (i < 8) ? i : 8);
            chk($sformatf("full_ready_%0d", i), rdy[0], (i < 8) ? 1'b1 : 1'b0);
        end
        vld[0] = 1'b0;
        chk("full_held_serial", ser[0], 1'b1);
        chk("full_held_busy", busy[0], 1'b1);
        @(negedge clk);
        en[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("full_first_pop_count", cnt[0], 7);
        for (int i = 0; i < 8; i++) sw[i] = 8'(i + 1);
        check_stream("full_stream", 8);

        // Push on the same edge the FSM pops, with three words queued.
        @(negedge clk);
        en[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tx_data = 8'h11 * 8'(i + 1);
            vld[0]  = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        chk("pp_count_before", cnt[0], 3);
        tx_data = 8'h44;
        en[0]   = 1'b1;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        chk("pp_count_same", cnt[0], 3);
        sw[0] = 8'h11;
        sw[1] = 8'h22;
        sw[2] = 8'h33;
        sw[3] = 8'h44;
        check_stream("pp_stream", 4);

        // Reset during the 4th data bit of 0x00.
        @(negedge clk);
        tx_data = 8'h00;
        vld[0]  = 1'b1;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        repeat (44) @(posedge clk);
        #3;
        chk("mid_bit3_low", ser[0], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_serial", ser[0], 1'b1);
        chk("mid_rst_busy", busy[0], 1'b0);
        chk("mid_rst_count", cnt[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int errs = 0;
            for (int k = 0; k < 20 * DIV; k++) begin
                @(posedge clk);
                #1;
                if (ser[0] !== 1'b1) errs++;
                if (busy[0] !== 1'b0) errs++;
                if (cnt[0] !== 4'd0) errs++;
            end
            chk("mid_post_release_idle", errs, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter with a configurable frame format: data width, parity mode and stop-bit count, fronted by a write FIFO. Replaces the fixed 8N1 transmitter in the serial TX path; the upstream producer pushes words through a valid/ready handshake and the block serialises them onto tx_serial. It adds a frame-boundary pause control and a FIFO occupancy output for flow-control logic.

Parameters:
CLK_FREQ, 1_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s; DIV = CLK_FREQ/BAUD_RATE (integer floor, must be ≥2)
FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, ≥2
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame; legal values 1 or 2

Ports:
clk  in  1  system clock; all logic is rising-edge
rst_n  in  1  asynchronous active-low reset
tx_data  in  DATA_BITS  word to transmit
tx_valid  in  1  producer asserts when tx_data is valid
tx_ready  out  1  high when the FIFO can accept a word (not full)
tx_enable  in  1  when low, no new frame starts; a frame in progress always completes
tx_serial  out  1  serial line; idles high
tx_busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): tx_serial=1, tx_busy=0, tx_ready=1, fifo_count=0, FIFO flushed, FSM in IDLE, baud counter=0, bit index=0.
- Write: the word is accepted on an edge where tx_valid && tx_ready. tx_ready = (fifo_count != FIFO_DEPTH), driven combinationally from the registered count. tx_valid while full is ignored; the word is not stored.
- Push and pop on the same edge: fifo_count is unchanged and both operations take effect. There is no FIFO bypass; a word always passes through the FIFO.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: when FIFO non-empty && tx_enable, pop the head into the shift register and enter START on the same edge. tx_serial is registered, so the start bit begins 1 cycle after the accept edge when the FIFO was empty.
- Each bit state holds for exactly DIV cycles, timed by a counter 0..DIV-1 that reloads on every state or bit change.
- START: drive 0. Then go to DATA.
- DATA: drive DATA_BITS bits, LSB first. After the last bit, go to PAR if PARITY != 0, otherwise to STOP.
- PAR: drive the XOR of the data bits for even parity; drive its inverse for odd parity.
- STOP: drive 1 for STOP_BITS×DIV cycles.
- End of STOP: if FIFO non-empty && tx_enable, pop and enter START directly, so frames are back-to-back with no idle gap. Otherwise go to IDLE.
- tx_enable deasserted mid-frame has no effect until the frame ends.
- tx_busy: combinational, (state != IDLE) || (fifo_count != 0).
- Reset mid-frame: tx_serial goes to 1 immediately (asynchronously) and the partial frame is lost. After release, the line is idle high.
- Parameter sanity checks are elaboration-time assertions; illegal values stop elaboration.

Test Plan:
1. 8N1, CLK_FREQ=1_000_000, BAUD_RATE=100_000 (DIV=10): push 0x55 -> tx_serial drives 0,1,0,1,0,1,0,1,0,1 with each bit 10 cycles wide; the start bit begins 1 cycle after the accept edge; tx_busy falls after the stop bit.
2. PARITY=1 then PARITY=2, DATA_BITS=8: push 0xA3 (popcount 4) -> parity bit is 0 for even and 1 for odd; frame length is 11×DIV cycles.
3. DATA_BITS=5, STOP_BITS=2: push 0x1F -> 1 start bit, 5 ones, then stop high for 20 cycles; bits above bit 4 of tx_data are never driven.
4. FIFO full: tx_enable=0, push 9 words 0x01..0x09 -> fifo_count reaches 8, tx_ready drops after the 8th word, 0x09 is dropped; raise tx_enable -> 0x01..0x08 go out back-to-back with no idle high gap beyond the stop bits.
5. Simultaneous push/pop: with the FIFO holding 3 words, push on the edge where the FSM pops -> fifo_count stays 3 and transmission order is preserved.
6. Reset mid-frame: assert rst_n=0 during the 4th data bit of 0x00 -> tx_serial=1 before the next clock edge; after release, fifo_count=0, tx_busy=0 and no residual frame is sent.
